dpram_fifo_ctrl: RTL and testbench
==================================

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, word width; RAM_AW, 16, RAM address port width; DEPTH, 256, RAM words used (power of two).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 clr  in  1  synchronous flush.
REQ-005 s_data  in  DATA_W  write-side word; s_valid  in  1; s_ready  out  1.
REQ-006 m_data  out  DATA_W  read-side word; m_valid  out  1; m_ready  in  1.
REQ-007 count  out  9  total words held (RAM + in-flight + output buffer); full  out  1; empty  out  1.
REQ-008 ram_addr_a  out  RAM_AW; ram_data_a  out  DATA_W; ram_we_a  out  1  (RAM port A, write-only use).
REQ-009 ram_addr_b  out  RAM_AW; ram_data_b  out  DATA_W (tied 0); ram_we_b  out  1 (tied 0); ram_q_b  in  DATA_W  (port B read data, registered inside the RAM, 1-cycle latency).

Function
REQ-010 Block SHALL implement a FIFO in the external 256x32 single-clock true dual-port RAM: port A writes, port B reads.
REQ-011 Push: s_valid && s_ready SHALL drive ram_we_a=1, ram_addr_a=wr_ptr zero-extended, ram_data_a=s_data that cycle; wr_ptr increments, wraps DEPTH-1 -> 0.
REQ-012 s_ready SHALL be !full; full SHALL be (mem_cnt == DEPTH); mem_cnt = words in RAM not yet read.
REQ-013 Read issue (combinational, same cycle): issue = (mem_cnt>0) && (obuf_cnt + inflight - pop < 2), where pop = m_valid && m_ready; ram_addr_b = rd_ptr zero-extended every cycle; rd_ptr increments on issue, wraps.
REQ-014 inflight SHALL be a 1-bit register set to issue; ram_q_b SHALL be captured into the output buffer on the edge ending a cycle where inflight=1.
REQ-015 Output buffer: 2-entry register FIFO; m_valid = (obuf_cnt>0); m_data = head entry, driven from registers only.
REQ-016 Latency: word accepted in cycle n SHALL appear on m_data with m_valid=1 in cycle n+3 when FIFO was empty and m_ready=1.
REQ-017 Throughput: with s_valid=1 and m_ready=1 continuously, SHALL sustain one push and one pop per cycle after the initial latency.
REQ-018 Ordering: words SHALL leave in acceptance order with no loss or duplication.
REQ-019 Simultaneous push and issue: never the same address (issue requires mem_cnt>0, push requires mem_cnt<DEPTH); mem_cnt += push - issue.
REQ-020 count = mem_cnt + inflight + obuf_cnt; empty = (count==0); max count = DEPTH+2.
REQ-021 m_data/m_valid SHALL hold stable while m_valid && !m_ready.
REQ-022 clr=1 SHALL, at the next edge, zero pointers, mem_cnt, inflight, obuf_cnt; clr has priority over push/pop that cycle; s_ready=0 during clr; a capture due that edge is discarded.

Reset
REQ-023 rst_n=0 SHALL immediately force: wr_ptr=0, rd_ptr=0, mem_cnt=0, inflight=0, obuf_cnt=0, buffer data=0.
REQ-024 Output values during reset: m_valid=0, m_data=0, count=0, empty=1, full=0, s_ready=1, ram_we_a=0, ram_addr_a=0, ram_data_a=0, ram_addr_b=0.
REQ-025 Reset mid-operation SHALL discard all contents; RAM contents are don't-care and never read before rewrite.

Structure
REQ-026 Package dpram_fifo_pkg SHALL hold DATA_W, RAM_AW, DEPTH defaults, pointer width (log2 DEPTH) and count width constants.
REQ-027 Sub-module fifo_obuf SHALL implement the 2-entry output buffer (push/pop/cnt/head); pointer/count logic stays in the top.

Verification
REQ-028 Reset, push 0xA5A5_0001 in cycle 0, m_ready=1 -> m_valid=1, m_data=0xA5A5_0001 in cycle 3; empty=1 after pop.
REQ-029 m_ready=0, push 258 words 0..257 -> full=1 after 256 RAM words, s_ready=0, count=258; then m_ready=1 -> words 0..257 out in order.
REQ-030 Continuous s_valid/m_ready=1 for 1000 cycles, incrementing data -> one word out per cycle from cycle 3, no gaps, rd/wr pointers wrap past 255 correctly.
REQ-031 Random m_ready (50%) with random s_valid, 5000 words -> scoreboard match, m_data stable under backpressure.
REQ-032 Fill 10 words, assert clr for 1 cycle while pushing -> next cycle count=0, empty=1, m_valid=0; pushed word dropped; next push 0x1234 emerges first.
REQ-033 rst_n low asynchronously mid-stream with 20 words held -> outputs take REQ-024 values without clock edge; post-reset push/pop correct.

Source files
------------

// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants for the dual-port-RAM backed FIFO controller.
package dpram_fifo_pkg;

   localparam int DATA_W_DEF = 32;                    // word width
   localparam int RAM_AW_DEF = 16;                    // external RAM address port width
   localparam int DEPTH_DEF  = 256;                   // RAM words used, power of two
   localparam int PTR_W      = $clog2(DEPTH_DEF);     // read/write pointer width
   localparam int MEM_CNT_W  = PTR_W + 1;             // 0..DEPTH words resident in RAM
   localparam int OBUF_CNT_W = 2;                     // 0..2 words in the output buffer
   localparam int CNT_W      = $clog2(DEPTH_DEF + 3); // 0..DEPTH+2 words held in total

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Stream handshake bundle between a producer/consumer and the FIFO controller.
//
// Handshake rule for both streams: a word moves on a rising clock edge exactly
// when valid and ready are both high in the cycle ending at that edge. The
// sender holds data stable while valid is high and ready is low. Ready may
// depend combinationally on controller state but never on the partner's valid.
interface dpram_fifo_ctrl_if #(
   parameter int DATA_W = 32
);

   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   // FIFO side: accepts the write stream, produces the read stream.
   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid
   );

   // Environment side: produces the write stream, consumes the read stream.
   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid
   );

endinterface

// File: rtl/dpram_fifo_ctrl_obuf.sv
// Two-entry register FIFO that absorbs the RAM read latency on the output side.
// Entry 0 is always the head, so the output word comes straight from a flop.
module fifo_obuf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [1:0]        cnt,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] ent0;
   logic [DATA_W-1:0] ent1;
   logic [1:0]        cnt_q;

   // Shift-register storage: pops move entry 1 forward, pushes fill the first free slot.
   // The controller never pushes into a full buffer unless it pops in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0  <= '0;
         ent1  <= '0;
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_q == 2'd0) ent0 <= din;
               else               ent1 <= din;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               ent0  <= ent1;
               cnt_q <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  ent0 <= din;
               end else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   // Head and occupancy are plain register outputs.
   always_comb begin
      cnt  = cnt_q;
      head = ent0;
   end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over an external single-clock true dual-port RAM.
// Port A only writes, port B only reads (1-cycle registered read data).
// A 1-bit in-flight flag plus a 2-entry output buffer hide the read latency
// and allow one push and one pop per cycle in steady state.
module dpram_fifo_ctrl
   import dpram_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RAM_AW = RAM_AW_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   dpram_fifo_ctrl_if.slave  bus,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic [RAM_AW-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_data_a,
   output logic              ram_we_a,
   output logic [RAM_AW-1:0] ram_addr_b,
   output logic [DATA_W-1:0] ram_data_b,
   output logic              ram_we_b,
   input  logic [DATA_W-1:0] ram_q_b
);

   localparam int PW = $clog2(DEPTH);
   localparam int MW = PW + 1;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [MW-1:0]         mem_cnt;
   logic                  inflight;
   logic [OBUF_CNT_W-1:0] obuf_cnt;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [2:0]            obuf_after;

   // Handshake decode and read-issue decision; a read is launched only if the
   // output buffer will still have room for it once the in-flight word lands.
   always_comb begin
      full        = (mem_cnt == MW'(DEPTH));
      bus.s_ready = !full && !clr;
      push        = bus.s_valid && bus.s_ready && rst_n;
      pop         = bus.m_valid && bus.m_ready;
      obuf_after  = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
      issue       = (mem_cnt != '0) && (obuf_after < 3'd2);
   end

   // RAM port drive: port A writes at the write pointer, port B always addresses the read pointer.
   always_comb begin
      ram_we_a   = push;
      ram_addr_a = RAM_AW'(wr_ptr);
      ram_data_a = push ? bus.s_data : '0;
      ram_addr_b = RAM_AW'(rd_ptr);
      ram_data_b = '0;
      ram_we_b   = 1'b0;
   end

   // Pointer, RAM occupancy and in-flight tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         inflight <= 1'b0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + PW'(1);
         if (issue) rd_ptr <= rd_ptr + PW'(1);
         mem_cnt  <= mem_cnt + MW'(push) - MW'(issue);
         inflight <= issue;
      end
   end

   // Output buffer captures RAM read data one cycle after each issue.
   fifo_obuf #(
      .DATA_W (DATA_W)
   ) u_obuf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (inflight),
      .din   (ram_q_b),
      .pop   (pop),
      .cnt   (obuf_cnt),
      .head  (bus.m_data)
   );

   // Status outputs: total occupancy spans RAM, the pending read and the buffer.
   always_comb begin
      bus.m_valid = (obuf_cnt != '0);
      count       = CNT_W'(mem_cnt) + CNT_W'(inflight) + CNT_W'(obuf_cnt);
      empty       = (count == '0);
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM, queue-based reference model,
// scenario tasks run in sequence from one initial block.
module tb_dpram_fifo_ctrl;
   import dpram_fifo_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int DEPTH = 256;
   localparam int PW    = $clog2(DEPTH);

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clr   = 1'b0;
   always #5 clk = ~clk;

   logic [CNT_W-1:0] count;
   logic             full, empty;
   logic [AW-1:0]    ram_addr_a, ram_addr_b;
   logic [DW-1:0]    ram_data_a, ram_data_b, ram_q_b;
   logic             ram_we_a, ram_we_b;

   dpram_fifo_ctrl_if #(.DATA_W(DW)) bus ();

   dpram_fifo_ctrl #(.DATA_W(DW), .RAM_AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .bus        (bus),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .ram_addr_a (ram_addr_a),
      .ram_data_a (ram_data_a),
      .ram_we_a   (ram_we_a),
      .ram_addr_b (ram_addr_b),
      .ram_data_b (ram_data_b),
      .ram_we_b   (ram_we_b),
      .ram_q_b    (ram_q_b)
   );

   // Behavioural 256x32 RAM: port A write, port B registered read.
   logic [DW-1:0] ram_mem [DEPTH];
   initial ram_q_b = '0;
   always @(posedge clk) begin
      if (ram_we_a) ram_mem[ram_addr_a[PW-1:0]] <= ram_data_a;
      ram_q_b <= ram_mem[ram_addr_b[PW-1:0]];
   end

   // ---------------- scoreboard ----------------
   int            checks   = 0;
   int            errors   = 0;
   int            pop_seen = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_word;
   logic          hold_prev = 1'b0;
   logic [DW-1:0] hold_data = '0;

   // Reference model: every accepted word is queued; every pop must return the oldest one.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         checks++;
         if (count !== CNT_W'(exp_q.size())) begin
            errors++;
            $display("FAIL count_model: got %0d want %0d", count, exp_q.size());
         end
         checks++;
         if (empty !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL empty_model: got %0b want %0b", empty, exp_q.size() == 0);
         end
         if (hold_prev) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== hold_data) begin
               errors++;
               $display("FAIL hold_stable: got v=%0b d=%h want v=1 d=%h", bus.m_valid, bus.m_data, hold_data);
            end
         end
         if (clr) begin
            exp_q.delete();
            hold_prev = 1'b0;
         end else begin
            if (bus.m_valid && bus.m_ready) begin
               pop_seen++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL pop_order: got %h want nothing (model empty)", bus.m_data);
               end else begin
                  exp_word = exp_q.pop_front();
                  if (bus.m_data !== exp_word) begin
                     errors++;
                     $display("FAIL pop_order: got %h want %h", bus.m_data, exp_word);
                  end
               end
            end
            if (bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
            hold_prev = bus.m_valid && !bus.m_ready;
            hold_data = bus.m_data;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int g;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      g = 0;
      while (!empty && g < 1000) begin
         tick();
         g++;
      end
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL %s_drain: got empty=%0b count=%0d want empty=1", name, empty, count);
      end
   endtask

   task automatic test_reset();
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hFFFF_FFFF;
      bus.m_ready = 1'b1;
      rst_n       = 1'b0;
      #1;
      checks++; if (bus.m_valid !== 1'b0)  begin errors++; $display("FAIL rst_m_valid: got %0b want 0", bus.m_valid); end
      checks++; if (bus.m_data !== '0)     begin errors++; $display("FAIL rst_m_data: got %h want 0", bus.m_data); end
      checks++; if (count !== '0)          begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
      checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL rst_empty: got %0b want 1", empty); end
      checks++; if (full !== 1'b0)         begin errors++; $display("FAIL rst_full: got %0b want 0", full); end
      checks++; if (bus.s_ready !== 1'b1)  begin errors++; $display("FAIL rst_s_ready: got %0b want 1", bus.s_ready); end
      checks++; if (ram_we_a !== 1'b0)     begin errors++; $display("FAIL rst_we_a: got %0b want 0", ram_we_a); end
      checks++; if (ram_addr_a !== '0)     begin errors++; $display("FAIL rst_addr_a: got %h want 0", ram_addr_a); end
      checks++; if (ram_data_a !== '0)     begin errors++; $display("FAIL rst_data_a: got %h want 0", ram_data_a); end
      checks++; if (ram_addr_b !== '0)     begin errors++; $display("FAIL rst_addr_b: got %h want 0", ram_addr_b); end
      checks++; if (ram_we_b !== 1'b0 || ram_data_b !== '0) begin
         errors++; $display("FAIL rst_port_b_tie: got we=%0b d=%h want we=0 d=0", ram_we_b, ram_data_b);
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      bus.s_data  = 32'hA5A5_0001;
      bus.s_valid = 1'b1;
      bus.m_ready = 1'b1;
      tick();                      // cycle 1
      bus.s_valid = 1'b0;
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1: got m_valid=%0b want 0", bus.m_valid); end
      tick();                      // cycle 2
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle2: got m_valid=%0b want 0", bus.m_valid); end
      tick();                      // cycle 3
      checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA5A5_0001) begin
         errors++; $display("FAIL lat_cycle3: got v=%0b d=%h want v=1 d=a5a50001", bus.m_valid, bus.m_data);
      end
      tick();                      // cycle 4
      checks++; if (empty !== 1'b1 || bus.m_valid !== 1'b0) begin
         errors++; $display("FAIL lat_after_pop: got empty=%0b v=%0b want empty=1 v=0", empty, bus.m_valid);
      end
   endtask

   task automatic test_fill();
      int g;
      int p0;
      bus.m_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         bus.s_data  = DW'(i);
         bus.s_valid = 1'b1;
         g = 0;
         while (!bus.s_ready && g < 50) begin
            tick();
            g++;
         end
         if (g >= 50) begin
            checks++; errors++;
            $display("FAIL fill_timeout: got s_ready=0 at word %0d want 1", i);
            break;
         end
         tick();
         if (i == DEPTH - 1) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_not_early: got full=%0b want 0", full); end
         end
      end
      bus.s_valid = 1'b0;
      checks++; if (full !== 1'b1)        begin errors++; $display("FAIL fill_full: got %0b want 1", full); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %0b want 0", bus.s_ready); end
      checks++; if (count !== CNT_W'(DEPTH + 2)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, DEPTH + 2); end
      p0 = pop_seen;
      drain("fill");
      checks++; if (pop_seen - p0 != DEPTH + 2) begin errors++; $display("FAIL fill_pops: got %0d want %0d", pop_seen - p0, DEPTH + 2); end
   endtask

   task automatic test_stream();
      int gaps;
      int p0;
      gaps = 0;
      p0   = pop_seen;
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         bus.s_data = 32'h1000_0000 + DW'(k);
         if (k >= 3 && !bus.m_valid) gaps++;
         tick();
      end
      bus.s_valid = 1'b0;
      checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
      checks++; if (pop_seen - p0 != 997) begin errors++; $display("FAIL stream_pops: got %0d want 997", pop_seen - p0); end
      drain("stream");
   endtask

   task automatic test_random();
      int acc;
      int cyc;
      acc = 0;
      cyc = 0;
      while (acc < 5000 && cyc < 40000) begin
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_data  = $urandom;
         bus.m_ready = 1'($urandom_range(0, 1));
         if (bus.s_valid && bus.s_ready) acc++;
         tick();
         cyc++;
      end
      checks++; if (acc != 5000) begin errors++; $display("FAIL random_accept: got %0d want 5000", acc); end
      drain("random");
   endtask

   task automatic test_clear();
      int g;
      bus.m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.s_data  = $urandom;
         bus.s_valid = 1'b1;
         tick();
      end
      clr         = 1'b1;
      bus.s_data  = 32'hDEAD_BEEF;
      bus.s_valid = 1'b1;
      #1;
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL clr_s_ready: got %0b want 0", bus.s_ready); end
      tick();
      clr         = 1'b0;
      bus.s_valid = 1'b0;
      checks++; if (count !== '0 || empty !== 1'b1 || bus.m_valid !== 1'b0) begin
         errors++; $display("FAIL clr_flush: got count=%0d empty=%0b v=%0b want 0/1/0", count, empty, bus.m_valid);
      end
      bus.s_data  = 32'h0000_1234;
      bus.s_valid = 1'b1;
      bus.m_ready = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      g = 0;
      while (!bus.m_valid && g < 10) begin
         tick();
         g++;
      end
      checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h0000_1234) begin
         errors++; $display("FAIL clr_first_word: got v=%0b d=%h want v=1 d=00001234", bus.m_valid, bus.m_data);
      end
      drain("clear");
   endtask

   task automatic test_async_reset();
      logic [109:0] obs;
      logic [109:0] req;
      bus.m_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.s_data  = $urandom;
         bus.s_valid = 1'b1;
         tick();
      end
      bus.s_data  = 32'hCAFE_F00D;
      bus.m_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      obs = {bus.m_valid, bus.m_data, count, empty, full, bus.s_ready, ram_we_a, ram_addr_a, ram_data_a, ram_addr_b};
      req = {1'b0, 32'h0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 16'h0};
      checks++; if (obs !== req) begin errors++; $display("FAIL async_reset_outputs: got %h want %h", obs, req); end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (count !== '0) begin errors++; $display("FAIL post_reset_count: got %0d want 0", count); end
      for (int i = 0; i < 30; i++) begin
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_data  = $urandom;
         bus.m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      drain("post_reset");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      test_reset();
      test_latency();
      test_fill();
      test_stream();
      test_random();
      test_clear();
      test_async_reset();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
